// File: rtl/uart_rx_fc.sv
// rtl/uart_rx_fc.sv - 8N1 UART receiver with FWFT byte FIFO and RTS flow control
module uart_rx_fc #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int FIFO_ADDR_BITS = 3,
  parameter int RTS_THRESHOLD  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       rts,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW    = FIFO_ADDR_BITS + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [NW-1:0] THRESH_N = NW'(RTS_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // synchronizer
  logic sync1_q, sync2_q;
  logic rxs;

  // receiver
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;

  // fifo and status
  logic [7:0]                mem_q [DEPTH];
  logic [7:0]                mem_d [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]             count_q, count_d;
  logic                      rts_q, rts_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      pop, full, push_ok;

  assign rxs = sync2_q;

  // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Receiver next state: mid-bit sampling, LSB first, stop check and break wait.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a pop in the push cycle frees the slot being written at full.
  always_comb begin
    pop       = (count_q != '0) && ready;
    full      = (count_q == DEPTH_N);
    push_ok   = push && (!full || pop);
    overrun_d = push && !push_ok;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + FIFO_ADDR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_BITS'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    rts_d = ((DEPTH_N - count_d) <= THRESH_N);
  end

  // FIFO storage, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rts_q       <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rts_q       <= rts_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = mem_q[rd_ptr_q];
  assign valid     = (count_q != '0);
  assign rts       = rts_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
